uart_tx_arbiter: RTL and testbench

- Shares the single UART controller transmit path between two byte requesters, e.g. the CPU store path and the debug/boot monitor.
- Grants round-robin, with an optional per-requester lock that keeps multi-byte messages contiguous.
- Paces writes with a holdoff counter so the controller's registered, late-updating TX-not-full status bit is never trusted stale.
- Sits between the requesters and the UART controller's wr_en/data/status_out interface.

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares the UART controller's single transmit path between two byte
// requesters (for example the CPU store path and the debug/boot monitor).
// Grants alternate round-robin. A requester can set its lock flag so that the
// grant stays with it and a multi-byte message goes out without interleaving.
// After every controller write the arbiter waits HOLDOFF cycles before it
// looks at the controller status again. The controller's TX-not-full bit is
// registered and updates late, so it cannot be trusted right after a write.
//
// Parameters
//   HOLDOFF       idle cycles after each write before status is re-sampled (1..15)
//   LOCK_TIMEOUT  idle cycles with the lock owner's valid low before the lock
//                 is forcibly released (1..255)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   reqN_valid/_data    requester N offers a byte. Held stable until ready.
//   reqN_lock           requester N wants to keep the grant after this byte
//   reqN_ready          one-cycle pulse: requester N's byte was accepted
//   uc_status           controller status, bit0 = TX FIFO not full
//   uc_wr_en            one-cycle write strobe to the controller
//   uc_data             {8'h00, granted byte}
//   grant_id            requester of the current or most recent grant
//   locked              grant_id currently holds the lock
//   lock_expired        one-cycle pulse when the lock is dropped by timeout
//   tx_count            bytes accepted since reset, wraps at 16 bits
module uart_tx_arbiter #(
    parameter int unsigned HOLDOFF      = 3,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_lock,
    output logic        req1_ready,
    input  logic [7:0]  uc_status,
    output logic        uc_wr_en,
    output logic [15:0] uc_data,
    output logic        grant_id,
    output logic        locked,
    output logic        lock_expired,
    output logic [15:0] tx_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD     = 4'(HOLDOFF);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(LOCK_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [7:0]  timer_q, timer_d;
    logic        grant_q, grant_d;
    logic        locked_q, locked_d;
    logic        expired_q, expired_d;
    logic        wr_q, wr_d;
    logic        ready0_q, ready0_d;
    logic        ready1_q, ready1_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] count_q, count_d;

    logic owner_valid;
    logic elig0;
    logic elig1;
    logic winner;
    logic unused_status;

    // Only the FIFO-not-full flag matters here. The other status bits are
    // reduced into a dummy so that the unused bits are visible as unused.
    assign unused_status = ^uc_status[7:1];

    // While locked, only the current grant holder may compete. On a tie the
    // requester that did not win last time gets the grant. Reset sets the
    // last grant to 1, so requester 0 wins the first tie.
    assign owner_valid = grant_q ? req1_valid : req0_valid;
    assign elig0       = req0_valid & (~locked_q | ~grant_q);
    assign elig1       = req1_valid & (~locked_q | grant_q);
    assign winner      = (elig0 & elig1) ? ~grant_q : elig1;

    // Next-state logic. The write strobe, the ready pulse and the byte count
    // are all registered on the edge that enters ISSUE. That way they are high
    // together during the ISSUE cycle, and a reset on that edge suppresses all
    // of them. The lock flag is taken from the requester during the ISSUE
    // cycle, while it is still holding the byte it was granted for.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        timer_d   = timer_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        byte_d    = byte_q;
        count_d   = count_q;
        expired_d = 1'b0;
        wr_d      = 1'b0;
        ready0_d  = 1'b0;
        ready1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The timeout decision does not change this cycle's
                // arbitration. The owner's valid is low here anyway, so the
                // owner cannot be granted in the same cycle.
                if (locked_q && !owner_valid) begin
                    if (timer_q + 8'd1 == TIMEOUT_LIMIT) begin
                        timer_d   = 8'd0;
                        locked_d  = 1'b0;
                        expired_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end else begin
                    timer_d = 8'd0;
                end

                if (uc_status[0] && (elig0 || elig1)) begin
                    grant_d  = winner;
                    byte_d   = winner ? req1_data : req0_data;
                    wr_d     = 1'b1;
                    ready0_d = ~winner;
                    ready1_d = winner;
                    count_d  = count_q + 16'd1;
                    timer_d  = 8'd0;
                    state_d  = ISSUE;
                end
            end

            ISSUE: begin
                locked_d = grant_q ? req1_lock : req0_lock;
                hold_d   = HOLD_LOAD;
                timer_d  = 8'd0;
                state_d  = HOLD;
            end

            HOLD: begin
                timer_d = 8'd0;
                hold_d  = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end

            default: begin
                timer_d = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset wins over everything, including a
    // write that would otherwise be launched on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= 4'd0;
            timer_q   <= 8'd0;
            grant_q   <= 1'b1;
            locked_q  <= 1'b0;
            expired_q <= 1'b0;
            wr_q      <= 1'b0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            byte_q    <= 8'd0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            expired_q <= expired_d;
            wr_q      <= wr_d;
            ready0_q  <= ready0_d;
            ready1_q  <= ready1_d;
            byte_q    <= byte_d;
            count_q   <= count_d;
        end
    end

    assign req0_ready   = ready0_q;
    assign req1_ready   = ready1_q;
    assign uc_wr_en     = wr_q;
    assign uc_data      = {8'h00, byte_q};
    assign grant_id     = grant_q;
    assign locked       = locked_q;
    assign lock_expired = expired_q;
    assign tx_count     = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter. Two requester drivers take bytes from per-requester
// queues. A reference model works from the arbitration rules using cycle
// arithmetic: a write blocks arbitration for HOLDOFF+2 cycles, there is an
// owner idle count, and round-robin runs on the last winner. From these the
// model predicts every registered output on every cycle. The scenario tasks
// add directed checks on latency, ordering, spacing and lock behaviour.
module tb_uart_tx_arbiter;

    localparam int HOLDOFF      = 3;
    localparam int LOCK_TIMEOUT = 64;

    typedef struct {
        logic [7:0] data;
        logic       lock;
        int         gap;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  uc_status = 8'h01;
    logic        req0_valid, req1_valid, req0_lock, req1_lock;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready, uc_wr_en, grant_id, locked, lock_expired;
    logic [15:0] uc_data, tx_count;

    logic        drvValid [2];
    logic        drvLock  [2];
    logic [7:0]  drvData  [2];
    item_t       reqQ [2][$];
    int          waitCnt [2];
    bit          ackPend [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outputs, written by the reference model
    logic        expWr, expR0, expR1, expGrant, expLocked, expExp;
    logic [7:0]  expData;
    logic [15:0] expTx;

    assign req0_valid = drvValid[0];
    assign req1_valid = drvValid[1];
    assign req0_data  = drvData[0];
    assign req1_data  = drvData[1];
    assign req0_lock  = drvLock[0];
    assign req1_lock  = drvLock[1];

    uart_tx_arbiter #(
        .HOLDOFF      (HOLDOFF),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_lock    (req0_lock),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_lock    (req1_lock),
        .req1_ready   (req1_ready),
        .uc_status    (uc_status),
        .uc_wr_en     (uc_wr_en),
        .uc_data      (uc_data),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_expired (lock_expired),
        .tx_count     (tx_count)
    );

    always #5 clk = ~clk;

    function automatic item_t mkItem(logic [7:0] d, logic l, int g);
        item_t it;
        it.data = d;
        it.lock = l;
        it.gap  = g;
        return it;
    endfunction

    function automatic logic [37:0] obsVec();
        return {uc_wr_en, req0_ready, req1_ready, grant_id, locked, lock_expired, uc_data, tx_count};
    endfunction

    function automatic logic [37:0] expVec();
        return {expWr, expR0, expR1, expGrant, expLocked, expExp, 8'h00, expData, expTx};
    endfunction

    // Requester drivers. A byte stays offered through the cycle where ready is
    // seen and is retired one cycle later. If the next byte has no gap, it is
    // then offered at once.
    initial begin
        for (int r = 0; r < 2; r++) begin
            drvValid[r] = 1'b0;
            drvLock[r]  = 1'b0;
            drvData[r]  = 8'h00;
            waitCnt[r]  = 0;
            ackPend[r]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (ackPend[r]) begin
                    if (reqQ[r].size() > 0) reqQ[r].delete(0);
                    drvValid[r] = 1'b0;
                    ackPend[r]  = 1'b0;
                    waitCnt[r]  = 0;
                end else if (drvValid[r] && ((r == 0) ? req0_ready : req1_ready)) begin
                    ackPend[r] = 1'b1;
                end
                if (!drvValid[r] && reqQ[r].size() > 0) begin
                    if (waitCnt[r] >= reqQ[r][0].gap) begin
                        drvValid[r] = 1'b1;
                        drvData[r]  = reqQ[r][0].data;
                        drvLock[r]  = reqQ[r][0].lock;
                    end else begin
                        waitCnt[r]++;
                    end
                end
            end
        end
    end

    // Reference model. After a write is decided in cycle c, it is visible in
    // c+1. The lock flag is taken in c+1, and arbitration resumes in
    // c+2+HOLDOFF. The lock owner's low-valid idle cycles are counted toward
    // LOCK_TIMEOUT.
    initial begin
        int nextDecide;
        int issueCycle;
        int idleLow;
        bit want0, want1, w, newLocked, ownerValid;
        nextDecide = 0;
        issueCycle = -1;
        idleLow    = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                expWr = 0; expR0 = 0; expR1 = 0; expExp = 0;
                expGrant = 1; expLocked = 0; expData = 8'h00; expTx = 16'h0000;
                nextDecide = cyc + 1;
                issueCycle = -1;
                idleLow    = 0;
            end else begin
                expWr = 0; expR0 = 0; expR1 = 0; expExp = 0;
                if (cyc == issueCycle) expLocked = expGrant ? req1_lock : req0_lock;
                if (cyc >= nextDecide) begin
                    want0      = req0_valid && (!expLocked || expGrant == 1'b0);
                    want1      = req1_valid && (!expLocked || expGrant == 1'b1);
                    ownerValid = expGrant ? req1_valid : req0_valid;
                    newLocked  = expLocked;
                    if (expLocked && !ownerValid) begin
                        idleLow++;
                        if (idleLow == LOCK_TIMEOUT) begin
                            newLocked = 0;
                            expExp    = 1;
                            idleLow   = 0;
                        end
                    end else begin
                        idleLow = 0;
                    end
                    if (uc_status[0] && (want0 || want1)) begin
                        w          = (want0 && want1) ? !expGrant : want1;
                        expGrant   = w;
                        expData    = w ? req1_data : req0_data;
                        expWr      = 1;
                        expR0      = !w;
                        expR1      = w;
                        expTx      = expTx + 16'd1;
                        issueCycle = cyc + 1;
                        nextDecide = cyc + 2 + HOLDOFF;
                        idleLow    = 0;
                    end
                    expLocked = newLocked;
                end else begin
                    idleLow = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        uc_status = 8'h01;
        for (int r = 0; r < 2; r++) begin
            reqQ[r].delete();
            drvValid[r] = 1'b0;
            ackPend[r]  = 1'b0;
            waitCnt[r]  = 0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqQ[0].push_back(mkItem(8'h33, 1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obsVec() !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
                bad++;
                $display("[TB] FAIL reset_values got=%h want=%h", obsVec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000});
            end
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
        end
        doReset();
    endtask

    task automatic test_single();
        int firstValid = -100;
        int wr1 = -100;
        int wr2 = -200;
        doReset();
        reqQ[0].push_back(mkItem(8'h41, 1'b0, 0));
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL single_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (req0_valid && firstValid < 0) firstValid = cyc;
            if (uc_wr_en && wr1 >= 0 && wr2 < 0) wr2 = cyc;
            if (uc_wr_en && wr1 < 0) begin
                wr1 = cyc;
                total++;
                if (uc_data !== 16'h0041 || tx_count !== 16'd1 || req0_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL single_first data=%h count=%0d ready=%b want 0041/1/1", uc_data, tx_count, req0_ready);
                end
                reqQ[0].push_back(mkItem(8'h42, 1'b0, 0));
            end
        end
        total++;
        if (wr1 - firstValid != 1) begin
            bad++;
            $display("[TB] FAIL single_latency got=%0d want=1", wr1 - firstValid);
        end
        total++;
        if (wr2 - wr1 != HOLDOFF + 2) begin
            bad++;
            $display("[TB] FAIL single_spacing got=%0d want=%0d", wr2 - wr1, HOLDOFF + 2);
        end
    endtask

    task automatic test_alternate();
        int wc[$];
        logic [7:0] wd[$];
        logic wg[$];
        doReset();
        for (int i = 0; i < 4; i++) begin
            reqQ[0].push_back(mkItem(8'hA0, 1'b0, 0));
            reqQ[1].push_back(mkItem(8'hB1, 1'b0, 0));
        end
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL alt_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (uc_wr_en) begin
                wc.push_back(cyc);
                wd.push_back(uc_data[7:0]);
                wg.push_back(grant_id);
            end
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] gotD = 8'hxx;
            logic gotG = 1'bx;
            int gap = -1;
            if (i < wd.size()) begin
                gotD = wd[i];
                gotG = wg[i];
            end
            if (i + 1 < wc.size()) gap = wc[i+1] - wc[i];
            total++;
            if (gotD !== ((i % 2 == 1) ? 8'hB1 : 8'hA0) || gotG !== 1'(i % 2) || gap != HOLDOFF + 2) begin
                bad++;
                $display("[TB] FAIL alt_order idx=%0d got data=%h grant=%b gap=%0d want data=%h grant=%0d gap=%0d",
                         i, gotD, gotG, gap, (i % 2 == 1) ? 8'hB1 : 8'hA0, i % 2, HOLDOFF + 2);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] wd[$];
        logic wg[$];
        logic la[$];
        logic prevWr = 1'b0;
        logic [7:0] expD [5] = '{8'hC1, 8'hC2, 8'hC3, 8'h20, 8'h21};
        logic       expG [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       expL [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        doReset();
        reqQ[0].push_back(mkItem(8'h10, 1'b0, 0));
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL lock_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (uc_wr_en) break;
        end
        reqQ[1].push_back(mkItem(8'hC1, 1'b1, 0));
        reqQ[1].push_back(mkItem(8'hC2, 1'b1, 0));
        reqQ[1].push_back(mkItem(8'hC3, 1'b0, 0));
        reqQ[0].push_back(mkItem(8'h20, 1'b0, 0));
        reqQ[0].push_back(mkItem(8'h21, 1'b0, 0));
        for (int i = 0; i < 60; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL lock_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (prevWr) la.push_back(locked);
            prevWr = uc_wr_en;
            if (uc_wr_en) begin
                wd.push_back(uc_data[7:0]);
                wg.push_back(grant_id);
            end
        end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] gotD = 8'hxx;
            logic gotG = 1'bx;
            logic gotL = 1'bx;
            if (i < wd.size()) begin
                gotD = wd[i];
                gotG = wg[i];
            end
            if (i < la.size()) gotL = la[i];
            total++;
            if (gotD !== expD[i] || gotG !== expG[i] || gotL !== expL[i]) begin
                bad++;
                $display("[TB] FAIL lock_order idx=%0d got data=%h grant=%b locked=%b want data=%h grant=%b locked=%b",
                         i, gotD, gotG, gotL, expD[i], expG[i], expL[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int w0 = -1000;
        int w1 = -1000;
        int expiredAt = -2000;
        logic g0 = 1'bx;
        logic g1 = 1'bx;
        logic [7:0] d1 = 8'hxx;
        doReset();
        reqQ[0].push_back(mkItem(8'h41, 1'b1, 0));
        reqQ[1].push_back(mkItem(8'hB2, 1'b0, 0));
        for (int i = 0; i < 150; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL timeout_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (lock_expired && expiredAt < 0) expiredAt = cyc;
            if (uc_wr_en && w0 >= 0 && w1 < 0) begin
                w1 = cyc;
                g1 = grant_id;
                d1 = uc_data[7:0];
            end
            if (uc_wr_en && w0 < 0) begin
                w0 = cyc;
                g0 = grant_id;
            end
        end
        total++;
        if (g0 !== 1'b0 || expiredAt - w0 != HOLDOFF + 1 + LOCK_TIMEOUT) begin
            bad++;
            $display("[TB] FAIL timeout_expiry grant=%b delay=%0d want grant=0 delay=%0d",
                     g0, expiredAt - w0, HOLDOFF + 1 + LOCK_TIMEOUT);
        end
        total++;
        if (w1 - expiredAt != 1 || g1 !== 1'b1 || d1 !== 8'hB2) begin
            bad++;
            $display("[TB] FAIL timeout_regrant delay=%0d grant=%b data=%h want 1/1/b2", w1 - expiredAt, g1, d1);
        end
    endtask

    task automatic test_status();
        int k;
        int w = -100;
        logic g = 1'bx;
        doReset();
        uc_status = 8'hFE;
        reqQ[0].push_back(mkItem(8'h55, 1'b0, 0));
        reqQ[1].push_back(mkItem(8'h66, 1'b0, 0));
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (uc_wr_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL status_block cyc=%0d wr=%b r0=%b r1=%b want 0/0/0", cyc, uc_wr_en, req0_ready, req1_ready);
            end
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL status_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
        end
        uc_status = 8'h01;
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL status_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (uc_wr_en && w < 0) begin
                w = cyc;
                g = grant_id;
            end
        end
        total++;
        if (w - k != 1 || g !== 1'b0) begin
            bad++;
            $display("[TB] FAIL status_resume delay=%0d grant=%b want 1/0", w - k, g);
        end
    endtask

    task automatic test_reset_issue();
        int writes = 0;
        doReset();
        uc_status = 8'h00;
        reqQ[0].push_back(mkItem(8'h5A, 1'b0, 0));
        step();
        step();
        rst       = 1'b1;
        uc_status = 8'h01;
        step();
        total++;
        if (uc_wr_en !== 1'b0 || req0_ready !== 1'b0 || tx_count !== 16'd0) begin
            bad++;
            $display("[TB] FAIL rst_issue wr=%b ready=%b count=%0d want 0/0/0", uc_wr_en, req0_ready, tx_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL rst_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
            if (uc_wr_en) writes++;
        end
        total++;
        if (writes != 1 || uc_data !== 16'h005A || tx_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL rst_reissue writes=%0d data=%h count=%0d want 1/005a/1", writes, uc_data, tx_count);
        end
    endtask

    task automatic test_random();
        int n = 0;
        doReset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) begin
                int g;
                g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(0, 3));
                reqQ[r].push_back(mkItem(8'($urandom), ($urandom_range(0, 3) == 0), g));
            end
        end
        while ((reqQ[0].size() > 0 || reqQ[1].size() > 0) && n < 8000) begin
            uc_status = {7'($urandom), ($urandom_range(0, 7) != 0)};
            step();
            n++;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", cyc, obsVec(), expVec());
            end
        end
        total++;
        if (n >= 8000 || tx_count !== 16'd80) begin
            bad++;
            $display("[TB] FAIL random_drain cycles=%0d count=%0d want count=80 within 8000", n, tx_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting uart_tx_arbiter bench");
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_timeout();
        test_status();
        test_reset_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
